// File: rtl/bus_wait_ram_if.sv
// bus_wait_ram_if: CPU asynchronous-style memory bus,
// seen from the CPU (master) or from one responder (slave).
interface bus_wait_ram_if;
  logic [15:0] a;
  logic [7:0]  d_in;
  logic [7:0]  d_out;
  logic        d_oe;
  logic        n_oe;
  logic        n_we;
  logic        n_rdy;

  modport master (
    output a, d_in, n_oe, n_we,
    input  d_out, d_oe, n_rdy
  );

  modport slave (
    input  a, d_in, n_oe, n_we,
    output d_out, d_oe, n_rdy
  );
endinterface

// File: rtl/bus_wait_ram.sv
// bus_wait_ram: windowed RAM responder on the CPU bus with
// programmable wait states; writes commit on strobe release.
module bus_wait_ram #(
  parameter logic [15:0] BASE_ADDR   = 16'h1000,
  parameter int unsigned ADDR_BITS   = 8,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input logic           clk,
  input logic           rst,
  bus_wait_ram_if.slave bus
);

  localparam int unsigned DEPTH = 1 << ADDR_BITS;
  localparam logic [3:0] CNT_INIT =
    (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_e;

  state_e               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [ADDR_BITS-1:0] addr_q;
  logic                 wr_q;
  logic [7:0]           data_q;
  logic [7:0]           dout_q;
  logic [7:0]           mem_q [DEPTH];

  logic                 sel;
  logic                 acc;
  logic                 is_wr;
  logic                 enter_done;
  logic                 commit;
  logic [ADDR_BITS-1:0] idx;

  assign sel   = bus.a[15:ADDR_BITS] == BASE_ADDR[15:ADDR_BITS];
  assign acc   = sel & (~bus.n_oe | ~bus.n_we);
  assign is_wr = ~bus.n_we;
  assign idx   = bus.a[ADDR_BITS-1:0];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_done = 1'b0;
    commit     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (acc) begin
          if (WAIT_CYCLES == 0) begin
            state_d    = DONE;
            enter_done = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (!acc) begin
          state_d = IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d    = DONE;
          enter_done = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        // leaving the window counts as release too
        if (!acc) begin
          state_d = IDLE;
          commit  = wr_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      data_q  <= 8'h00;
      dout_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (enter_done) begin
        addr_q <= idx;
        wr_q   <= is_wr;
        data_q <= bus.d_in;
        if (!is_wr) dout_q <= mem_q[idx];
      end
    end
  end

  // storage is deliberately not reset
  always_ff @(posedge clk) begin
    if (!rst && commit) mem_q[addr_q] <= data_q;
  end

  assign bus.n_rdy = acc & (state_q != DONE);
  assign bus.d_oe  = sel & ~bus.n_oe & bus.n_we
                   & (state_q == DONE) & ~wr_q;
  assign bus.d_out = dout_q;

endmodule

// File: tb/tb_bus_wait_ram.sv
// tb_bus_wait_ram: two responders (2 and 0 wait states),
// randomized CPU accesses checked against a plain memory model.
module tb_bus_wait_ram;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bus_wait_ram_if b0 ();
  bus_wait_ram_if b1 ();

  bus_wait_ram #(
    .BASE_ADDR  (16'h1000),
    .ADDR_BITS  (8),
    .WAIT_CYCLES(2)
  ) u0 (
    .clk(clk),
    .rst(rst),
    .bus(b0.slave)
  );

  bus_wait_ram #(
    .BASE_ADDR  (16'h1000),
    .ADDR_BITS  (8),
    .WAIT_CYCLES(0)
  ) u1 (
    .clk(clk),
    .rst(rst),
    .bus(b1.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] ref_mem [2][256];
  bit         known   [2][256];
  logic [7:0] exp_q0 [$];
  logic [7:0] exp_q1 [$];
  bit seen0 = 1'b0;
  bit seen1 = 1'b0;

  function automatic void chk(string nm, int act, int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)",
               nm, act, req, $time);
    end
  endfunction

  task automatic drive(input int w, input logic [15:0] ad,
                       input logic [7:0] dv,
                       input bit noe, input bit nwe);
    if (w == 0) begin
      b0.a = ad; b0.d_in = dv; b0.n_oe = noe; b0.n_we = nwe;
    end else begin
      b1.a = ad; b1.d_in = dv; b1.n_oe = noe; b1.n_we = nwe;
    end
  endtask

  function automatic int get_rdy(int w);
    return (w == 0) ? int'(b0.n_rdy) : int'(b1.n_rdy);
  endfunction

  function automatic int get_doe(int w);
    return (w == 0) ? int'(b0.d_oe) : int'(b1.d_oe);
  endfunction

  function automatic int get_dout(int w);
    return (w == 0) ? int'(b0.d_out) : int'(b1.d_out);
  endfunction

  // Monitors: every d_oe assertion must match a queued read.
  always @(negedge clk) begin
    if (b0.d_oe && !seen0) begin
      seen0 = 1'b1;
      if (exp_q0.size() == 0) chk("unexp_doe0", int'(b0.d_oe), 0);
      else chk("rd_data0", int'(b0.d_out), int'(exp_q0.pop_front()));
    end else if (!b0.d_oe) begin
      seen0 = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (b1.d_oe && !seen1) begin
      seen1 = 1'b1;
      if (exp_q1.size() == 0) chk("unexp_doe1", int'(b1.d_oe), 0);
      else chk("rd_data1", int'(b1.d_out), int'(exp_q1.pop_front()));
    end else if (!b1.d_oe) begin
      seen1 = 1'b0;
    end
  end

  // One CPU access. abort>0: drop strobe after that many edges.
  task automatic access(input int w, input logic [15:0] ad,
                        input logic [7:0] dv, input bit we,
                        input bit oe, input int abort,
                        input bit rst_done);
    int  wc;
    int  hi;
    bit  in_win;
    bit  is_rd;
    wc     = (w == 0) ? 2 : 0;
    hi     = 0;
    in_win = (ad[15:8] == 8'h10);
    is_rd  = oe && !we;
    @(posedge clk);
    #1;
    drive(w, ad, dv, !oe, !we);
    if (in_win && is_rd && abort == 0 && !rst_done) begin
      if (w == 0) exp_q0.push_back(ref_mem[0][ad[7:0]]);
      else        exp_q1.push_back(ref_mem[1][ad[7:0]]);
    end
    if (abort > 0) begin
      repeat (abort) @(posedge clk);
      #1;
      chk("abort_in_wait", get_rdy(w), 1);
      drive(w, 16'h0000, 8'h00, 1'b1, 1'b1);
      @(posedge clk);
      #1;
      return;
    end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (get_rdy(w) != 0) hi++;
      else break;
    end
    chk("wait_states", hi, (in_win && (we || oe)) ? wc + 1 : 0);
    if (we) drive(w, ad, ~dv, !oe, !we);
    @(posedge clk);
    #1;
    if (rst_done) begin
      rst = 1'b1;
      drive(w, ad, dv, 1'b1, 1'b1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst_dout", get_dout(w), 0);
      chk("rst_doe", get_doe(w), 0);
    end else begin
      drive(w, ad, dv, 1'b1, 1'b1);
      #1;
      chk("doe_release", get_doe(w), 0);
      if (in_win && we) begin
        ref_mem[w][ad[7:0]] = dv;
        known[w][ad[7:0]]   = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    drive(w, 16'h0000, 8'h00, 1'b1, 1'b1);
  endtask

  logic [7:0]  lo;
  logic [7:0]  dv;
  logic [7:0]  last_w [2];
  int          w;
  int          op;

  initial begin
    rst = 1'b1;
    drive(0, 16'h0000, 8'h00, 1'b1, 1'b1);
    drive(1, 16'h0000, 8'h00, 1'b1, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_n_rdy", get_rdy(k), 0);
      chk("rst_d_oe", get_doe(k), 0);
      chk("rst_d_out", get_dout(k), 0);
    end
    rst = 1'b0;

    access(0, 16'h1010, 8'hA5, 1, 0, 0, 0);
    access(0, 16'h1010, 8'h00, 0, 1, 0, 0);
    access(0, 16'h2010, 8'h00, 0, 1, 0, 0);
    access(0, 16'h1020, 8'h77, 1, 0, 0, 0);
    access(0, 16'h1020, 8'h11, 1, 0, 1, 0);
    access(0, 16'h1020, 8'h00, 0, 1, 0, 0);
    access(0, 16'h1020, 8'h22, 1, 0, 0, 1);
    access(0, 16'h1020, 8'h00, 0, 1, 0, 0);
    access(1, 16'h1001, 8'h3C, 1, 1, 0, 0);
    access(1, 16'h1001, 8'h00, 0, 1, 0, 0);
    last_w[0] = 8'h20;
    last_w[1] = 8'h01;

    for (int n = 0; n < 150; n++) begin
      w  = int'($urandom_range(0, 1));
      op = int'($urandom_range(0, 5));
      lo = 8'($urandom);
      dv = 8'($urandom);
      case (op)
        0, 1: begin
          access(w, {8'h10, lo}, dv, 1, bit'($urandom_range(0, 1)), 0, 0);
          last_w[w] = lo;
        end
        2: begin
          if (known[w][lo]) access(w, {8'h10, lo}, dv, 0, 1, 0, 0);
          else access(w, {8'h10, lo}, dv, 1, 0, 0, 0);
          if (!known[w][lo]) last_w[w] = lo;
        end
        3: access(w, {($urandom_range(0, 1) != 0) ? 8'h20 : 8'h0F, lo},
                  dv, bit'($urandom_range(0, 1)), 1, 0, 0);
        4: begin
          if (w == 0) access(0, {8'h10, lo}, dv, 1, 0, 1, 0);
          else access(1, {8'h10, last_w[1]}, dv, 0, 1, 0, 0);
        end
        default: access(w, {8'h10, last_w[w]}, dv, 0, 1, 0, 0);
      endcase
    end

    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("q_drain", exp_q0.size() + exp_q1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
